// File: rtl/alu.sv
// Registered 8-bit ALU: 20 opcodes, carry/borrow chaining, status flags.
// Ports: clk, rst (sync, high), opcode, operand_A/B, enable, input_ready,
//   carry_in, borrow_in -> result_out, result_ready, carry_out,
//   borrow_out, zero, negative, overflow. Define ALU_ROTATE_EN for ROL/ROR.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [7:0] operand_A,
  input  logic [7:0] operand_B,
  input  logic       enable,
  input  logic       input_ready,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic [7:0] result_out,
  output logic       result_ready,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       zero,
  output logic       negative,
  output logic       overflow
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NAND = 5'd7;
  localparam logic [4:0] OP_NOR  = 5'd8;
  localparam logic [4:0] OP_XNOR = 5'd9;
  localparam logic [4:0] OP_NOT  = 5'd10;
  localparam logic [4:0] OP_INC  = 5'd11;
  localparam logic [4:0] OP_DEC  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_SHR  = 5'd14;
  localparam logic [4:0] OP_SAR  = 5'd15;
`ifdef ALU_ROTATE_EN
  localparam logic [4:0] OP_ROL  = 5'd16;
  localparam logic [4:0] OP_ROR  = 5'd17;
`endif
  localparam logic [4:0] OP_NEG  = 5'd18;
  localparam logic [4:0] OP_CMP  = 5'd19;

  logic [7:0] a;
  logic [7:0] b;
  logic [8:0] wide;
  logic [7:0] val;
  logic       c_n;
  logic       b_n;
  logic       v_n;
  logic       legal;
  logic       accept;

  assign a = operand_A;
  assign b = operand_B;

  // Bit 8 of the 9-bit sum/difference is the carry or borrow.
  always_comb begin
    wide  = '0;
    val   = '0;
    c_n   = 1'b0;
    b_n   = 1'b0;
    v_n   = 1'b0;
    legal = 1'b1;
    case (opcode)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        val  = wide[7:0];
        c_n  = wide[8];
        v_n  = (a[7] == b[7]) && (val[7] != a[7]);
      end
      OP_ADC: begin
        wide = {1'b0, a} + {1'b0, b}
             + {8'd0, carry_in};
        val  = wide[7:0];
        c_n  = wide[8];
        v_n  = (a[7] == b[7]) && (val[7] != a[7]);
      end
      OP_SUB, OP_CMP: begin
        wide = {1'b0, a} - {1'b0, b};
        val  = wide[7:0];
        b_n  = wide[8];
        v_n  = (a[7] != b[7]) && (val[7] != a[7]);
      end
      OP_SBB: begin
        wide = {1'b0, a} - {1'b0, b}
             - {8'd0, borrow_in};
        val  = wide[7:0];
        b_n  = wide[8];
        v_n  = (a[7] != b[7]) && (val[7] != a[7]);
      end
      OP_AND:  val = a & b;
      OP_OR:   val = a | b;
      OP_XOR:  val = a ^ b;
      OP_NAND: val = ~(a & b);
      OP_NOR:  val = ~(a | b);
      OP_XNOR: val = ~(a ^ b);
      OP_NOT:  val = ~a;
      OP_INC: begin
        wide = {1'b0, a} + 9'd1;
        val  = wide[7:0];
        c_n  = wide[8];
        v_n  = (a == 8'h7F);
      end
      OP_DEC: begin
        wide = {1'b0, a} - 9'd1;
        val  = wide[7:0];
        b_n  = wide[8];
        v_n  = (a == 8'h80);
      end
      OP_SHL: begin
        val = {a[6:0], 1'b0};
        c_n = a[7];
      end
      OP_SHR: begin
        val = {1'b0, a[7:1]};
        c_n = a[0];
      end
      OP_SAR: begin
        val = {a[7], a[7:1]};
        c_n = a[0];
      end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin
        val = {a[6:0], a[7]};
        c_n = a[7];
      end
      OP_ROR: begin
        val = {a[0], a[7:1]};
        c_n = a[0];
      end
`endif
      OP_NEG: begin
        wide = 9'd0 - {1'b0, a};
        val  = wide[7:0];
        b_n  = wide[8];
        v_n  = (a == 8'h80);
      end
      default: legal = 1'b0;
    endcase
  end

  assign accept = enable & input_ready & legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_out   <= '0;
      result_ready <= 1'b0;
      carry_out    <= 1'b0;
      borrow_out   <= 1'b0;
      zero         <= 1'b0;
      negative     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_ready <= accept;
      if (accept) begin
        // CMP updates flags only.
        if (opcode != OP_CMP)
          result_out <= val;
        carry_out  <= c_n;
        borrow_out <= b_n;
        zero       <= (val == 8'd0);
        negative   <= val[7];
        overflow   <= v_n;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed cases plus randomized scoreboard run.
// Expected responses queued by the driver, popped by a monitor.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [7:0] operand_A;
  logic [7:0] operand_B;
  logic       enable;
  logic       input_ready;
  logic       carry_in;
  logic       borrow_in;
  logic [7:0] result_out;
  logic       result_ready;
  logic       carry_out;
  logic       borrow_out;
  logic       zero;
  logic       negative;
  logic       overflow;

  always #5 clk = ~clk;

  alu dut (
    .clk(clk),
    .rst(rst),
    .opcode(opcode),
    .operand_A(operand_A),
    .operand_B(operand_B),
    .enable(enable),
    .input_ready(input_ready),
    .carry_in(carry_in),
    .borrow_in(borrow_in),
    .result_out(result_out),
    .result_ready(result_ready),
    .carry_out(carry_out),
    .borrow_out(borrow_out),
    .zero(zero),
    .negative(negative),
    .overflow(overflow)
  );

`ifdef ALU_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic [7:0] res;
    logic rdy, c, b, z, n, v;
  } exp_t;

  exp_t       q[$];
  exp_t       hold;
  bit         armed = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] mres = 8'd0;

  function automatic logic [13:0] pk(input exp_t e);
    return {e.res, e.rdy, e.c, e.b, e.z, e.n, e.v};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {result_out, result_ready, carry_out,
            borrow_out, zero, negative, overflow};
  endfunction

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic bit model(input int op, input int a,
                               input int b, input int ci,
                               input int bi,
                               input logic [7:0] prev,
                               output exp_t e);
    int sa, sb, r, sv;
    bit ar;
    logic [7:0] r8;
    e = '{default: 0};
    if (op > 19) return 1'b0;
    if (!ROT && (op == 16 || op == 17)) return 1'b0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = 0; sv = 0; ar = 1'b0;
    case (op)
      0:  begin r = a + b; e.c = (r > 255);
            sv = sa + sb; ar = 1; end
      1:  begin r = a + b + ci; e.c = (r > 255);
            sv = sa + sb + ci; ar = 1; end
      2, 19: begin r = a - b; e.b = (a < b);
            sv = sa - sb; ar = 1; end
      3:  begin r = a - b - bi; e.b = (a < b + bi);
            sv = sa - sb - bi; ar = 1; end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 255 - (a & b);
      8:  r = 255 - (a | b);
      9:  r = 255 - (a ^ b);
      10: r = 255 - a;
      11: begin r = a + 1; e.c = (r > 255);
            sv = sa + 1; ar = 1; end
      12: begin r = a - 1; e.b = (a < 1);
            sv = sa - 1; ar = 1; end
      13: begin r = a * 2; e.c = (a >= 128); end
      14: begin r = a / 2; e.c = (a % 2 == 1); end
      15: begin r = a / 2 + ((a >= 128) ? 128 : 0);
            e.c = (a % 2 == 1); end
      16: begin r = (a * 2) % 256 + a / 128;
            e.c = (a >= 128); end
      17: begin r = a / 2 + (a % 2) * 128;
            e.c = (a % 2 == 1); end
      18: begin r = 0 - a; e.b = (a > 0);
            sv = 0 - sa; ar = 1; end
      default: r = 0;
    endcase
    r8 = r[7:0];
    e.res = (op == 19) ? prev : r8;
    e.z = (r8 == 8'd0);
    e.n = (r8 >= 8'd128);
    e.v = ar && (sv > 127 || sv < -128);
    e.rdy = 1'b1;
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit en,
                      input bit ir, input int op,
                      input int a, input int b,
                      input int ci, input int bi);
    exp_t e;
    rst = r; enable = en; input_ready = ir;
    opcode = op[4:0];
    operand_A = a[7:0]; operand_B = b[7:0];
    carry_in = ci[0]; borrow_in = bi[0];
    if (r) begin
      e = '{default: 0};
      q.push_back(e);
      mres = 8'd0;
      armed = 1'b1;
    end else if (en && ir &&
                 model(op, a, b, ci, bi, mres, e)) begin
      q.push_back(e);
      mres = e.res;
    end
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [13:0] act,
                     input logic [13:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got res=%h rdy/c/b/z/n/v=%b want res=%h rdy/c/b/z/n/v=%b",
               nm, act[13:6], act[5:0], want[13:6], want[5:0]);
    end
  endtask

  // Monitor: an entry is due after every edge that should change outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          hold = e;
          hold.rdy = 1'b0;
          chk("update", dut_vec(), pk(e));
        end else begin
          chk("hold", dut_vec(), pk(hold));
        end
      end
    end
  end

  initial begin
    int op, a, b;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset", dut_vec(), 14'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle", dut_vec(), 14'd0);

    step(0, 1, 1, 0, 'h7F, 'h7E, 0, 0);
    chk("add", dut_vec(), {8'hFD, 6'b100011});
    step(0, 1, 1, 1, 'hFF, 'h00, 1, 0);
    chk("adc", dut_vec(), {8'h00, 6'b110100});
    step(0, 1, 1, 2, 'h00, 'h01, 0, 0);
    chk("sub", dut_vec(), {8'hFF, 6'b101010});
    step(0, 1, 1, 3, 'h05, 'h03, 0, 1);
    chk("sbb", dut_vec(), {8'h01, 6'b100000});
    step(0, 1, 1, 15, 'h81, 0, 0, 0);
    chk("sar", dut_vec(), {8'hC0, 6'b110010});
    step(0, 1, 1, 20, 'h12, 'h34, 0, 0);
    chk("illegal", dut_vec(), {8'hC0, 6'b010010});
    step(0, 0, 1, 0, 'h01, 'h01, 0, 0);
    chk("disabled", dut_vec(), {8'hC0, 6'b010010});
    step(0, 1, 1, 16, 'h81, 0, 0, 0);
    if (ROT)
      chk("rol", dut_vec(), {8'h03, 6'b110000});
    else
      chk("rol_off", dut_vec(), {8'hC0, 6'b010010});
    step(0, 1, 1, 18, 'h80, 0, 0, 0);
    chk("neg80", dut_vec(), {8'h80, 6'b101011});
    step(0, 1, 1, 19, 'h10, 'h10, 0, 0);
    chk("cmp", dut_vec(), {8'h80, 6'b100100});
    step(1, 1, 1, 0, 'h01, 'h01, 0, 0);
    chk("rst_req", dut_vec(), 14'd0);

    for (int i = 0; i < 20; i++)
      step(0, 1, 1, i, $urandom_range(0, 255),
           $urandom_range(0, 255), 1, 1);

    for (int i = 0; i < 800; i++) begin
      op = ($urandom % 4 != 0) ? $urandom_range(0, 19)
                               : $urandom_range(0, 31);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom % 5 == 0) a = ($urandom % 2) ? 'h80 : 'h7F;
      if ($urandom % 5 == 0) b = ($urandom % 2) ? 'hFF : 'h00;
      step(($urandom % 60) == 0, ($urandom % 8) != 0,
           ($urandom % 8) != 0, op, a, b,
           $urandom % 2, $urandom % 2);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
